quad_gray_decoder: RTL
======================

Name: quad_gray_decoder

Overview:
Downstream consumer of the 2-bit Gray-code counter stage. It samples the 2-bit Gray sequence each clock and classifies every transition as forward, reverse, none or illegal. It keeps a wrapping up/down position count and flags illegal jumps. It turns the raw Gray output into a binary position plus direction and step pulses for later logic and display.

Parameters:
CNT_W, 8, width of the position counter (two's-complement wrap, >=2)

Ports:
clk       input   1      system clock; all state updates on posedge only
rst       input   1      synchronous, active-high reset
en        input   1      count enable; 0 freezes count/step/dir but tracking continues
gray_in   input   2      Gray-coded phase from upstream counter (same clock domain, registered at source)
clr_err   input   1      synchronous clear of sticky error flag
count     output  CNT_W  position count
dir       output  1      direction of last valid step: 1 = forward, 0 = reverse
step      output  1      one-cycle pulse on each counted step
err       output  1      sticky illegal-transition flag
err_cnt   output  4      saturating count of illegal transitions

Behaviour:
- Reset (rst=1 at posedge): count=0, dir=0, step=0, err=0, err_cnt=0, g_q=2'b00, primed=0. Reset overrides every other input.
- No synchronizer: gray_in comes from a same-clock register.
- Internal state: g_q is the last sampled gray_in. primed is 0 until the first post-reset sample.
- First edge with rst=0: g_q<=gray_in, primed<=1, no classification, step=0.
- Every later edge: convert to binary with b = {g[1], g[1]^g[0]}. Compute d = (b(gray_in) - b(g_q)) mod 4.
  - d=0: NONE.
  - d=1: FWD.
  - d=3: REV.
  - d=2: ILLEGAL (both bits changed).
  - g_q<=gray_in at every edge, regardless of en.
- Forward sequence is 00->01->11->10->00.
- FWD with en=1: count<=count+1 (wraps 2^CNT_W-1 -> 0), dir<=1, step<=1.
- REV with en=1: count<=count-1 (wraps 0 -> 2^CNT_W-1), dir<=0, step<=1.
- NONE, or en=0: count and dir hold, step<=0.
- ILLEGAL (independent of en): count and dir hold, step<=0, err<=1, err_cnt<=err_cnt+1 saturating at 15.
- clr_err=1: err<=0 and err_cnt<=0, unless an ILLEGAL transition occurs in the same cycle. In that case err<=1 and err_cnt<=1 (set wins).
- Latency: a gray_in change registered upstream at edge N is classified at edge N+1. count, dir and step are valid after edge N+1.
- step is high for exactly one cycle per counted transition. Back-to-back transitions on consecutive edges give consecutive step pulses.
- Reset mid-operation clears everything, including primed. The first post-reset sample never counts, even if gray_in differs from 00.
- Outputs are all registered; no combinational path from inputs to outputs.

Test Plan:
- Reset, then en=1 and gray_in stepping 00,01,11,10,00,01 one per cycle -> count ends at 5, dir=1, 5 step pulses (the priming sample does not count), err=0.
- From count=5, gray_in 01,00,10,11,01 -> count=1, dir=0, 4 step pulses. Then hold gray_in constant 10 cycles -> count=1, step=0 throughout.
- Preload to 255 by forward steps (CNT_W=8), one more FWD -> count=0. Then one REV -> count=255, dir=0.
- gray_in 00->11 -> err=1, err_cnt=1, count unchanged, step=0. Then 11->10 (FWD) counts normally and err stays 1. Pulse clr_err -> err=0, err_cnt=0. ILLEGAL and clr_err in the same cycle -> err=1, err_cnt=1.
- en=0 during 00->01->11 -> count frozen, step=0. Raise en while gray_in=11, next transition 11->10 -> count+1 (tracking kept during en=0).
- Assert rst while count=37 -> next edge count=0, all flags 0. Release rst with gray_in=11 -> no step on the priming edge, and the next FWD (11->10) gives count=1.

Source files
------------

// File: rtl/quad_gray_decoder.sv
// rtl/quad_gray_decoder.sv - 2-bit Gray phase decoder with wrapping position count and illegal-jump tracking
//
// Purpose: samples a same-clock 2-bit Gray phase every cycle, classifies each
// transition as none / forward / reverse / illegal, and maintains a binary
// position count, direction, step pulse and error flags.
//
// Ports:
//   clk      - system clock, all state updates on posedge
//   rst      - synchronous active-high reset, overrides all other inputs
//   en       - count enable; 0 freezes count/dir/step, phase tracking continues
//   gray_in  - Gray-coded phase (registered at source, same clock)
//   clr_err  - synchronous clear of err / err_cnt (an illegal jump in the same cycle wins)
//   count    - CNT_W-bit wrapping position count
//   dir      - direction of last counted step (1 = forward, 0 = reverse)
//   step     - one-cycle pulse per counted step
//   err      - sticky illegal-transition flag
//   err_cnt  - illegal-transition count, saturating at 15

module quad_gray_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       gray_in,
    input  logic             clr_err,
    output logic [CNT_W-1:0] count,
    output logic             dir,
    output logic             step,
    output logic             err,
    output logic [3:0]       err_cnt
);

    typedef enum logic [1:0] {
        TR_NONE = 2'd0,
        TR_FWD  = 2'd1,
        TR_REV  = 2'd2,
        TR_ILL  = 2'd3
    } trans_e;

    logic [CNT_W-1:0] count_q, count_d;
    logic             dir_q, dir_d;
    logic             step_q, step_d;
    logic             err_q, err_d;
    logic [3:0]       err_cnt_q, err_cnt_d;
    logic [1:0]       g_q, g_d;
    logic             primed_q, primed_d;

    logic [1:0]       b_new;
    logic [1:0]       b_old;
    logic [1:0]       delta;
    trans_e           trans;

    always_comb begin
        // Gray to binary; the 2-bit subtraction wraps mod 4 naturally.
        b_new = {gray_in[1], gray_in[1] ^ gray_in[0]};
        b_old = {g_q[1], g_q[1] ^ g_q[0]};
        delta = b_new - b_old;

        trans = TR_NONE;
        if (primed_q) begin
            unique case (delta)
                2'd1:    trans = TR_FWD;
                2'd3:    trans = TR_REV;
                2'd2:    trans = TR_ILL;
                default: trans = TR_NONE;
            endcase
        end

        count_d   = count_q;
        dir_d     = dir_q;
        step_d    = 1'b0;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        g_d       = gray_in;
        primed_d  = 1'b1;

        if (en && trans == TR_FWD) begin
            count_d = count_q + CNT_W'(1);
            dir_d   = 1'b1;
            step_d  = 1'b1;
        end else if (en && trans == TR_REV) begin
            count_d = count_q - CNT_W'(1);
            dir_d   = 1'b0;
            step_d  = 1'b1;
        end

        if (clr_err) begin
            err_d     = 1'b0;
            err_cnt_d = 4'd0;
        end

        // Applied after the clear so a simultaneous illegal jump leaves err=1, err_cnt=1.
        if (trans == TR_ILL) begin
            err_d = 1'b1;
            if (err_cnt_d != 4'd15) begin
                err_cnt_d = err_cnt_d + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            dir_q     <= 1'b0;
            step_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= 4'd0;
            g_q       <= 2'b00;
            primed_q  <= 1'b0;
        end else begin
            count_q   <= count_d;
            dir_q     <= dir_d;
            step_q    <= step_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            g_q       <= g_d;
            primed_q  <= primed_d;
        end
    end

    assign count   = count_q;
    assign dir     = dir_q;
    assign step    = step_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;

endmodule
